// File: rtl/cpu_axil_master_if.sv
// cpu_axil_master_if: AXI-Lite bus between the CPU-side master bridge and a memory slave
interface cpu_axil_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );
  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/cpu_axil_master.sv
// cpu_axil_master: single-outstanding CPU request/response port to AXI-Lite master bridge
module cpu_axil_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  cpu_axil_master_if.master     m_axil
);
  localparam int OFF = $clog2(STRB_WIDTH);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;
  state_t state_q, state_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic misaligned;
  assign misaligned = |req_addr_i[OFF-1:0];
  assign req_ready_o = state_q == IDLE && !rst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign m_axil.awaddr = addr_q;
  assign m_axil.araddr = addr_q;
  assign m_axil.awprot = 3'b000;
  assign m_axil.arprot = 3'b000;
  assign m_axil.wdata = wdata_q;
  assign m_axil.wstrb = wstrb_q;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wvalid = wvalid_q;
  assign m_axil.bready = bready_q;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready = rready_q;
  // next-state and registered-output computation; each valid clears only on its own handshake
  always_comb begin
    state_d = state_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    bready_d = bready_q;
    arvalid_d = arvalid_q;
    rready_d = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d = req_addr_i;
        wdata_d = req_wdata_i;
        wstrb_d = req_wstrb_i;
        state_d = misaligned ? RESP : req_we_i ? WR : RD_ADDR;
        rsp_valid_d = misaligned;
        rsp_err_d = misaligned;
        rsp_rdata_d = '0;
        awvalid_d = !misaligned && req_we_i;
        wvalid_d = !misaligned && req_we_i;
        arvalid_d = !misaligned && !req_we_i;
      end
      WR: begin
        awvalid_d = awvalid_q && !m_axil.awready;
        wvalid_d = wvalid_q && !m_axil.wready;
        bready_d = !awvalid_d && !wvalid_d;
        state_d = bready_d ? WR_RESP : WR;
      end
      WR_RESP: if (m_axil.bvalid) begin
        bready_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d = m_axil.bresp != 2'b00;
        rsp_rdata_d = '0;
        state_d = RESP;
      end
      RD_ADDR: if (m_axil.arready) begin
        arvalid_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: if (m_axil.rvalid) begin
        rready_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d = m_axil.rresp != 2'b00;
        rsp_rdata_d = m_axil.rdata;
        state_d = RESP;
      end
      RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end
endmodule

// File: tb/tb_cpu_axil_master.sv
// tb_cpu_axil_master: directed bench with AXI-Lite memory slave and transaction-level reference model
module tb_cpu_axil_master;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_wstrb = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_rdata;
  cpu_axil_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  cpu_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .m_axil(bus)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask
  // slave: configurable ready delays, response codes and a B-channel hold
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0] bresp_cfg = 0, rresp_cfg = 0;
  logic b_hold = 0;
  int aw_cnt, w_cnt, ar_cnt, b_cnt = 0, ar_hs = 0;
  logic aw_got, w_got, bpend;
  logic [31:0] aw_a, w_d;
  logic [3:0] w_s;
  logic [31:0] smem [0:255];
  logic aw_now, w_now;
  logic [31:0] a_now, d_now;
  logic [3:0] s_now;
  function automatic logic [31:0] smerge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    smerge = old;
    for (int i = 0; i < 4; i++) if (s[i]) smerge[i*8 +: 8] = d[i*8 +: 8];
  endfunction
  assign bus.awready = bus.awvalid && aw_cnt >= aw_dly;
  assign bus.wready = bus.wvalid && w_cnt >= w_dly;
  assign bus.arready = bus.arvalid && ar_cnt >= ar_dly;
  assign bus.bvalid = bpend && !b_hold;
  assign aw_now = aw_got || (bus.awvalid && bus.awready);
  assign w_now = w_got || (bus.wvalid && bus.wready);
  assign a_now = aw_got ? aw_a : bus.awaddr;
  assign d_now = w_got ? w_d : bus.wdata;
  assign s_now = w_got ? w_s : bus.wstrb;
  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 0; w_got <= 0; bpend <= 0; bus.rvalid <= 0;
    end else begin
      aw_cnt <= bus.awvalid && !bus.awready ? aw_cnt + 1 : 0;
      w_cnt <= bus.wvalid && !bus.wready ? w_cnt + 1 : 0;
      ar_cnt <= bus.arvalid && !bus.arready ? ar_cnt + 1 : 0;
      if (bus.awvalid && bus.awready) begin aw_got <= 1; aw_a <= bus.awaddr; end
      if (bus.wvalid && bus.wready) begin w_got <= 1; w_d <= bus.wdata; w_s <= bus.wstrb; end
      if (aw_now && w_now && !bpend) begin
        smem[a_now[9:2]] <= smerge(smem[a_now[9:2]], d_now, s_now);
        bpend <= 1; bus.bresp <= bresp_cfg; aw_got <= 0; w_got <= 0;
      end else if (bus.bvalid && bus.bready) begin
        bpend <= 0; b_cnt <= b_cnt + 1;
      end
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1; bus.rdata <= smem[bus.araddr[9:2]]; bus.rresp <= rresp_cfg; ar_hs <= ar_hs + 1;
      end else if (bus.rvalid && bus.rready) bus.rvalid <= 0;
    end
  end
  // reference model: per accepted request the response it must produce, plus AXI-Lite channel rules
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t q[$];
  logic [31:0] mmem [0:255];
  int cyc = 0, acc_cyc, aw_cyc, w_cyc, ar_cyc, rsp_cyc, n_rsp = 0;
  logic busy = 0, cur_we, cur_mis, rst_prev = 1, rsp_prev = 0;
  logic [31:0] cur_addr, cur_data, hold_rdata, mask;
  logic [3:0] cur_strb;
  logic hold_err, rsp_hold = 0, aw_pend = 0, w_pend = 0, ar_pend = 0, aw_fp = 0, w_fp = 0, ar_fp = 0;
  always @(negedge clk) begin
    cyc++;
    chk("req_ready", req_ready, !rst && !busy);
    chk("awprot", bus.awprot, 0);
    chk("arprot", bus.arprot, 0);
    if (rst_prev) chk("reset_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}, 0);
    else begin
      chk("aw_legal", bus.awvalid && !(busy && cur_we && !cur_mis && bus.awaddr == cur_addr), 0);
      chk("w_legal", bus.wvalid && !(busy && cur_we && !cur_mis && bus.wdata == cur_data && bus.wstrb == cur_strb), 0);
      chk("ar_legal", bus.arvalid && !(busy && !cur_we && !cur_mis && bus.araddr == cur_addr), 0);
      if (aw_pend) chk("aw_hold", bus.awvalid, 1);
      if (w_pend) chk("w_hold", bus.wvalid, 1);
      if (ar_pend) chk("ar_hold", bus.arvalid, 1);
      if (aw_fp) chk("aw_drop", bus.awvalid, 0);
      if (w_fp) chk("w_drop", bus.wvalid, 0);
      if (ar_fp) chk("ar_drop", bus.arvalid, 0);
      if (rsp_hold) chk("rsp_stable", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, hold_err, hold_rdata});
      if (rsp_valid) begin
        if (q.size() == 0) fail("rsp_spurious");
        else begin
          chk("rsp_rdata", rsp_rdata, q[0].rdata);
          chk("rsp_err", rsp_err, q[0].err);
        end
      end
    end
    aw_fp = bus.awvalid && bus.awready;
    w_fp = bus.wvalid && bus.wready;
    ar_fp = bus.arvalid && bus.arready;
    if (aw_fp) aw_cyc = cyc;
    if (w_fp) w_cyc = cyc;
    if (ar_fp) ar_cyc = cyc;
    if (rsp_valid && !rsp_prev) rsp_cyc = cyc;
    aw_pend = bus.awvalid && !bus.awready && !rst;
    w_pend = bus.wvalid && !bus.wready && !rst;
    ar_pend = bus.arvalid && !bus.arready && !rst;
    rsp_hold = rsp_valid && !rsp_ready && !rst;
    hold_err = rsp_err;
    hold_rdata = rsp_rdata;
    rsp_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      busy = 0;
      if (q.size() != 0) void'(q.pop_front());
    end
    if (req_valid && req_ready) begin
      cur_we = req_we; cur_addr = req_addr; cur_data = req_wdata; cur_strb = req_wstrb;
      cur_mis = req_addr % 4 != 0;
      busy = 1;
      acc_cyc = cyc;
      if (cur_mis) q.push_back('{32'h0, 1'b1});
      else if (cur_we) begin
        mask = {{8{req_wstrb[3]}}, {8{req_wstrb[2]}}, {8{req_wstrb[1]}}, {8{req_wstrb[0]}}};
        mmem[req_addr[9:2]] = (mmem[req_addr[9:2]] & ~mask) | (req_wdata & mask);
        q.push_back('{32'h0, bresp_cfg != 0});
      end else q.push_back('{mmem[req_addr[9:2]], rresp_cfg != 0});
    end
    if (rst) begin busy = 0; q.delete(); end
    rst_prev = rst;
  end
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output int lat, output logic [31:0] rd, output logic er);
    int n;
    @(posedge clk); #2;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) fail("accept");
    @(posedge clk); #2;
    req_valid = 0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_valid) fail("response");
    rd = rsp_rdata; er = rsp_err;
    repeat (hold) @(negedge clk);
    @(posedge clk); #2;
    rsp_ready = 1;
    @(posedge clk); #2;
    rsp_ready = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, b0, r0, a0, n;
    logic [31:0] rd;
    logic er;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("init_rsp_valid", rsp_valid, 0);
    chk("init_rsp_err", rsp_err, 0);
    chk("init_rsp_rdata", rsp_rdata, 0);
    chk("init_req_ready", req_ready, 1);
    chk("init_axi", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    do_req(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, lat, rd, er);
    chk("wr_lat", lat, 3);
    chk("wr_aw_hs", aw_cyc - acc_cyc, 1);
    chk("wr_w_hs", w_cyc - acc_cyc, 1);
    chk("wr_rdata", rd, 0);
    chk("wr_err", er, 0);
    do_req(0, 32'h100, 0, 0, 0, lat, rd, er);
    chk("rd_lat", lat, 3);
    chk("rd_ar_hs", ar_cyc - acc_cyc, 1);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_err", er, 0);
    do_req(1, 32'h100, 32'h00001234, 4'b0011, 0, lat, rd, er);
    do_req(0, 32'h100, 0, 0, 0, lat, rd, er);
    chk("partial_rdata", rd, 32'hDEAD1234);
    aw_dly = 3; b0 = b_cnt; r0 = n_rsp;
    do_req(1, 32'h104, 32'hCAFEF00D, 4'hF, 0, lat, rd, er);
    aw_dly = 0;
    chk("wfirst_w_hs", w_cyc - acc_cyc, 1);
    chk("wfirst_aw_hs", aw_cyc - acc_cyc, 4);
    chk("wfirst_lat", lat, 6);
    chk("wfirst_b_count", b_cnt - b0, 1);
    chk("wfirst_rsp_count", n_rsp - r0, 1);
    ar_dly = 2;
    do_req(0, 32'h104, 0, 0, 0, lat, rd, er);
    ar_dly = 0;
    chk("ar_slow_lat", lat, 5);
    chk("ar_slow_rdata", rd, 32'hCAFEF00D);
    a0 = ar_hs; b0 = b_cnt;
    do_req(0, 32'h102, 0, 0, 0, lat, rd, er);
    chk("mis_rd_lat", lat, 1);
    chk("mis_rd_err", er, 1);
    chk("mis_rd_rdata", rd, 0);
    chk("mis_rd_no_ar", ar_hs - a0, 0);
    do_req(1, 32'h101, 32'hFFFFFFFF, 4'hF, 0, lat, rd, er);
    chk("mis_wr_lat", lat, 1);
    chk("mis_wr_err", er, 1);
    chk("mis_wr_no_b", b_cnt - b0, 0);
    rresp_cfg = 2'b10;
    do_req(0, 32'h104, 0, 0, 5, lat, rd, er);
    rresp_cfg = 0;
    chk("rresp_err", er, 1);
    chk("rresp_rdata", rd, 32'hCAFEF00D);
    bresp_cfg = 2'b10;
    do_req(1, 32'h10C, 32'h55, 4'hF, 2, lat, rd, er);
    bresp_cfg = 0;
    chk("bresp_err", er, 1);
    chk("bresp_rdata", rd, 0);
    b_hold = 1;
    @(posedge clk); #2;
    req_valid = 1; req_we = 1; req_addr = 32'h108; req_wdata = 32'h11112222; req_wstrb = 4'hF;
    @(negedge clk);
    chk("rst_t_accept", req_ready, 1);
    @(posedge clk); #2;
    req_valid = 0;
    n = 0;
    @(negedge clk);
    while (!bus.bready && n < 20) begin @(negedge clk); n++; end
    if (!bus.bready) fail("rst_t_bready");
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    rst = 0; b_hold = 0;
    @(negedge clk);
    chk("rst_t_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}, 0);
    chk("rst_t_ready", req_ready, 1);
    do_req(0, 32'h108, 0, 0, 0, lat, rd, er);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", rd, 32'h11112222);
    chk("post_rst_err", er, 0);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
